data_plexer_arb: RTL

- Registered, handshaked successor to the combinational data plexer.
- Selects one of 2**SEL input channels, each INPUT_WIDTH bits wide, under one of three modes: manual select, fixed priority, or round-robin.
- Presents the chosen word in a single-entry output register with valid/ready flow control.
- The one-hot data_en is registered alongside the data, so downstream logic knows which channel the held word came from.

---
 rtl/data_plexer_arb_if.sv | 29 ++
 rtl/data_plexer_arb.sv | 110 +++++++++++
 2 files changed

// File: rtl/data_plexer_arb_if.sv
// Handshake bundle between the channel sources, the arbitrating plexer and its consumer.
// The master modport belongs to the environment; the slave modport belongs to the plexer.
interface data_plexer_arb_if #(
    parameter int INPUT_WIDTH = 4,
    parameter int SEL         = 2
);
    localparam int N = 1 << SEL;

    logic [INPUT_WIDTH*N-1:0] data_in;
    logic [N-1:0]             in_valid;
    logic [N-1:0]             in_ready;
    logic [1:0]               mode;
    logic [SEL-1:0]           sel_ctrl;
    logic [INPUT_WIDTH-1:0]   data_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [N-1:0]             data_en;
    logic [SEL-1:0]           grant_idx;

    modport master (
        output data_in, in_valid, mode, sel_ctrl, out_ready,
        input  in_ready, data_out, out_valid, data_en, grant_idx
    );

    modport slave (
        input  data_in, in_valid, mode, sel_ctrl, out_ready,
        output in_ready, data_out, out_valid, data_en, grant_idx
    );
endinterface

// File: rtl/data_plexer_arb.sv
// Registered, handshaked N-way data plexer.
// Arbitration modes: manual select, fixed priority or round-robin. One output word is held at a time.
module data_plexer_arb #(
    parameter int INPUT_WIDTH = 4,
    parameter int SEL         = 2
) (
    input  logic                clk,
    input  logic                rst,
    data_plexer_arb_if.slave    bus
);
    localparam int N = 1 << SEL;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;

    // First requester at or above start, wrapping N-1 -> 0. Offsets wrap naturally in SEL bits.
    function automatic void pick_first(
        input  logic [N-1:0]   req,
        input  logic [SEL-1:0] start,
        output logic           found,
        output logic [SEL-1:0] idx
    );
        logic [SEL-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = start + SEL'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SEL-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [INPUT_WIDTH-1:0] data_p0;
    logic [N-1:0]           en_p0;
    logic [SEL-1:0]         gidx_p0;
    logic                   vld_p0;
    logic [SEL-1:0]         rr_ptr;

    logic                   load_en;
    logic                   gnt_found;
    logic [SEL-1:0]         gnt;
    logic                   xfer;
    logic [INPUT_WIDTH-1:0] gnt_word;

    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        unique case (bus.mode)
            MODE_MANUAL: begin
                gnt_found = bus.in_valid[bus.sel_ctrl];
                gnt       = bus.sel_ctrl;
            end
            MODE_FIXED:  pick_first(bus.in_valid, '0, gnt_found, gnt);
            default:     pick_first(bus.in_valid, rr_ptr, gnt_found, gnt);
        endcase
    end

    // Accept only when the holding register is empty or draining this cycle.
    assign load_en  = !vld_p0 || bus.out_ready;
    assign xfer     = load_en && gnt_found && !rst;
    assign gnt_word = bus.data_in[gnt*INPUT_WIDTH +: INPUT_WIDTH];

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready = onehot(gnt);
        end
    end

    // ---- stage p0: output holding register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            en_p0   <= '0;
            data_p0 <= '0;
            gidx_p0 <= '0;
        end else if (xfer) begin
            vld_p0  <= 1'b1;
            en_p0   <= onehot(gnt);
            data_p0 <= gnt_word;
            gidx_p0 <= gnt;
        end else if (vld_p0 && bus.out_ready) begin
            vld_p0  <= 1'b0;
            en_p0   <= '0;
        end
    end

    // Pointer advances only on round-robin transfers, so it survives visits to other modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer && bus.mode[1]) begin
            rr_ptr <= gnt + SEL'(1);
        end
    end

    assign bus.data_out  = data_p0;
    assign bus.out_valid = vld_p0;
    assign bus.data_en   = en_p0;
    assign bus.grant_idx = gidx_p0;
endmodule
